// File: rtl/bus_pkg.sv
// Shared constants for the two-master register-bus arbiter.
// FSM state encoding, default timeout and bus widths.
package bus_pkg;

  localparam int BUS_AW      = 32;
  localparam int BUS_DW      = 32;
  localparam int DEF_TIMEOUT = 16;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_XFER = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

endpackage

// File: rtl/rr_arb2.sv
// Combinational 2-way round-robin pick; zero latency, no backpressure.
// iLAST=0 means M0 held the last grant, iLAST=1 means M1 did.
module rr_arb2 (
  input  logic [1:0] iREQ,
  input  logic       iLAST,
  output logic [1:0] oGNT
);

  always_comb begin
    oGNT = 2'b00;
    case (iREQ)
      2'b01:   oGNT = 2'b01;
      2'b10:   oGNT = 2'b10;
      2'b11:   oGNT = iLAST ? 2'b01 : 2'b10;
      default: oGNT = 2'b00;
    endcase
  end

endmodule

// File: rtl/bus_rr_arbiter.sv
// Two-master round-robin arbiter onto one register slave, with transfer timeout.
// STB->ACK is 3 cycles (IDLE/XFER/RESP); masters hold STB until their ACK/ERR pulse.
module bus_rr_arbiter
  import bus_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int CNT_W   = 8
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic              iM0_STB,
  input  logic              iM0_WE,
  input  logic [BUS_AW-1:0] iM0_ADR,
  input  logic [BUS_DW-1:0] iM0_DAT,
  output logic [BUS_DW-1:0] oM0_DAT,
  output logic              oM0_ACK,
  output logic              oM0_ERR,
  input  logic              iM1_STB,
  input  logic              iM1_WE,
  input  logic [BUS_AW-1:0] iM1_ADR,
  input  logic [BUS_DW-1:0] iM1_DAT,
  output logic [BUS_DW-1:0] oM1_DAT,
  output logic              oM1_ACK,
  output logic              oM1_ERR,
  output logic              oS_STB,
  output logic              oS_WE,
  output logic [BUS_AW-1:0] oS_ADR,
  output logic [BUS_DW-1:0] oS_DAT,
  input  logic [BUS_DW-1:0] iS_DAT,
  input  logic              iS_ACK,
  output logic [1:0]        oGNT
);

  localparam logic [CNT_W-1:0] LP_TMO_LAST = CNT_W'(TIMEOUT - 1);

  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  logic [1:0]        r_gnt;
  logic [1:0]        w_pick;
  logic              r_last;
  logic [CNT_W-1:0]  r_cnt;
  logic              w_sel;
  logic              w_req_stb;
  logic              w_req_we;
  logic [BUS_AW-1:0] w_req_adr;
  logic [BUS_DW-1:0] w_req_dat;
  logic              w_xfer;
  logic              w_abort;
  logic              w_ack;
  logic              w_tmo;
  logic [BUS_DW-1:0] r_m0_dat;
  logic [BUS_DW-1:0] r_m1_dat;
  logic              r_m0_ack;
  logic              r_m1_ack;
  logic              r_m0_err;
  logic              r_m1_err;

  rr_arb2 u_pick (
    .iREQ  ({iM1_STB, iM0_STB}),
    .iLAST (r_last),
    .oGNT  (w_pick)
  );

  assign w_sel     = r_gnt[1];
  assign w_req_stb = w_sel ? iM1_STB : iM0_STB;
  assign w_req_we  = w_sel ? iM1_WE  : iM0_WE;
  assign w_req_adr = w_sel ? iM1_ADR : iM0_ADR;
  assign w_req_dat = w_sel ? iM1_DAT : iM0_DAT;

  assign w_xfer  = (r_state == ST_XFER);
  assign w_abort = w_xfer & ~w_req_stb;
  assign w_ack   = w_xfer & w_req_stb & iS_ACK;
  // ACK takes priority over a timeout landing in the same cycle.
  assign w_tmo   = w_xfer & w_req_stb & ~iS_ACK & (r_cnt == LP_TMO_LAST);

  always_ff @(posedge iCLK) begin
    if (iRST) r_state <= ST_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (|w_pick) w_state_nxt = ST_XFER;
      ST_XFER: begin
        if (w_abort)            w_state_nxt = ST_IDLE;
        else if (w_ack | w_tmo) w_state_nxt = ST_RESP;
      end
      ST_RESP: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Slave side is gated by the live request so an aborting master never reaches the slave.
  always_comb begin
    oS_STB = w_xfer & w_req_stb;
    oS_WE  = 1'b0;
    oS_ADR = '0;
    oS_DAT = '0;
    oGNT   = 2'b00;
    if (oS_STB) begin
      oS_WE  = w_req_we;
      oS_ADR = w_req_adr;
      oS_DAT = w_req_dat;
    end
    if (r_state != ST_IDLE) oGNT = r_gnt;
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_gnt    <= 2'b00;
      r_last   <= 1'b1;
      r_cnt    <= '0;
      r_m0_dat <= '0;
      r_m1_dat <= '0;
      r_m0_ack <= 1'b0;
      r_m1_ack <= 1'b0;
      r_m0_err <= 1'b0;
      r_m1_err <= 1'b0;
    end else begin
      r_m0_ack <= 1'b0;
      r_m1_ack <= 1'b0;
      r_m0_err <= 1'b0;
      r_m1_err <= 1'b0;
      if ((r_state == ST_IDLE) && (|w_pick)) r_gnt <= w_pick;
      if (w_xfer && !w_abort) r_cnt <= r_cnt + 1'b1;
      else                    r_cnt <= '0;
      if (w_ack) begin
        if (w_sel) begin
          r_m1_ack <= 1'b1;
          r_m1_dat <= w_req_we ? '0 : iS_DAT;
        end else begin
          r_m0_ack <= 1'b1;
          r_m0_dat <= w_req_we ? '0 : iS_DAT;
        end
      end else if (w_tmo) begin
        if (w_sel) begin
          r_m1_err <= 1'b1;
          r_m1_dat <= '0;
        end else begin
          r_m0_err <= 1'b1;
          r_m0_dat <= '0;
        end
      end
      if (r_state == ST_RESP) r_last <= w_sel;
    end
  end

  assign oM0_DAT = r_m0_dat;
  assign oM1_DAT = r_m1_dat;
  assign oM0_ACK = r_m0_ack;
  assign oM1_ACK = r_m1_ack;
  assign oM0_ERR = r_m0_err;
  assign oM1_ERR = r_m1_err;

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Bench for bus_rr_arbiter: register slave model plus a response scoreboard.
module tb_bus_rr_arbiter;

  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  m_stb;
  logic [1:0]  m_we;
  logic [31:0] m_adr [2];
  logic [31:0] m_dat [2];

  logic [31:0] oM0_DAT, oM1_DAT, oS_ADR, oS_DAT;
  logic        oM0_ACK, oM0_ERR, oM1_ACK, oM1_ERR, oS_STB, oS_WE;
  logic [1:0]  oGNT;

  logic        s_hit;
  logic [31:0] s_rdat;
  wire  [31:0] s_dat;
  logic        s_ack;
  int          s_wait = 0;
  int          s_wcnt = 0;

  always #5 clk = ~clk;

  bus_rr_arbiter #(.TIMEOUT(TMO), .CNT_W(8)) dut (
    .iCLK(clk), .iRST(rst),
    .iM0_STB(m_stb[0]), .iM0_WE(m_we[0]), .iM0_ADR(m_adr[0]), .iM0_DAT(m_dat[0]),
    .oM0_DAT(oM0_DAT), .oM0_ACK(oM0_ACK), .oM0_ERR(oM0_ERR),
    .iM1_STB(m_stb[1]), .iM1_WE(m_we[1]), .iM1_ADR(m_adr[1]), .iM1_DAT(m_dat[1]),
    .oM1_DAT(oM1_DAT), .oM1_ACK(oM1_ACK), .oM1_ERR(oM1_ERR),
    .oS_STB(oS_STB), .oS_WE(oS_WE), .oS_ADR(oS_ADR), .oS_DAT(oS_DAT),
    .iS_DAT(s_dat), .iS_ACK(s_ack), .oGNT(oGNT)
  );

  function automatic logic [32:0] slave_map(input logic [31:0] adr);
    case (adr)
      32'h0200_0100: slave_map = {1'b1, 32'h0123_4567};
      32'h0200_0104: slave_map = {1'b1, 32'h89AB_CDEF};
      32'h0200_0108: slave_map = {1'b1, 32'hFEDC_BA98};
      default:       slave_map = {1'b0, 32'h0000_0000};
    endcase
  endfunction

  // Slave acks combinationally after s_wait stalled strobe cycles; data is z otherwise.
  always_comb {s_hit, s_rdat} = slave_map(oS_ADR);
  assign s_ack = oS_STB && s_hit && (s_wcnt >= s_wait);
  assign s_dat = s_ack ? s_rdat : 32'hzzzz_zzzz;
  always @(posedge clk) s_wcnt <= (oS_STB && !s_ack) ? s_wcnt + 1 : 0;

  typedef struct {
    int          mst;
    logic        err;
    logic [31:0] dat;
  } rsp_t;

  rsp_t        sb[$];
  int          n_chk = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          last_rsp_cyc = 0;
  int          stb_cyc = 0;
  int          rem [2];
  int          t0;
  logic        s_we_seen;
  logic [31:0] s_adr_seen, s_dat_seen;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic expect_rsp(input int m, input logic we, input logic [31:0] adr);
    rsp_t        e;
    logic [32:0] hd;
    hd    = slave_map(adr);
    e.mst = m;
    e.err = !hd[32];
    e.dat = (hd[32] && !we) ? hd[31:0] : 32'h0;
    sb.push_back(e);
  endtask

  task automatic req(input int m, input logic we, input logic [31:0] adr,
                     input logic [31:0] dat, input int n);
    m_we[m]  = we;
    m_adr[m] = adr;
    m_dat[m] = dat;
    rem[m]   = n;
    m_stb[m] = 1'b1;
  endtask

  // One cycle: sample at negedge, score any response, drop STB of finished masters.
  task automatic step();
    rsp_t e;
    int   m;
    @(negedge clk);
    cyc++;
    if (oS_STB) begin
      stb_cyc++;
      s_we_seen  = oS_WE;
      s_adr_seen = oS_ADR;
      s_dat_seen = oS_DAT;
    end
    if (oM0_ACK || oM0_ERR || oM1_ACK || oM1_ERR) begin
      last_rsp_cyc = cyc;
      m = (oM1_ACK || oM1_ERR) ? 1 : 0;
      check("rsp_one_master", {62'd0, oM0_ACK | oM0_ERR, oM1_ACK | oM1_ERR},
            (m == 1) ? 64'd1 : 64'd2);
      check("rsp_expected", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("rsp_mst", m, e.mst);
        check("rsp_err", (m == 1) ? oM1_ERR : oM0_ERR, e.err);
        check("rsp_ack", (m == 1) ? oM1_ACK : oM0_ACK, !e.err);
        check("rsp_dat", (m == 1) ? oM1_DAT : oM0_DAT, e.dat);
      end
      if (rem[m] > 0) begin
        rem[m]--;
        if (rem[m] == 0) m_stb[m] = 1'b0;
      end
    end
  endtask

  task automatic run(input string tag, input int budget);
    int k = 0;
    while (sb.size() != 0 && k < budget) begin
      step();
      k++;
    end
    check({"drain_", tag}, sb.size(), 0);
    step();
    step();
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ctl"}, {56'd0, oS_STB, oS_WE, oGNT, oM0_ACK, oM0_ERR, oM1_ACK, oM1_ERR}, 0);
    check({tag, "_sadr"}, oS_ADR, 0);
    check({tag, "_sdat"}, oS_DAT, 0);
  endtask

  task automatic do_reset(input int n);
    rst   = 1'b1;
    m_stb = 2'b00;
    rem   = '{0, 0};
    repeat (n) step();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    m_we  = 2'b00;
    m_adr = '{32'h0, 32'h0};
    m_dat = '{32'h0, 32'h0};
    do_reset(3);
    rst = 1'b1;
    check_zero("reset");
    check("reset_m0dat", oM0_DAT, 0);
    check("reset_m1dat", oM1_DAT, 0);
    rst = 1'b0;

    // Single read; latency counts the IDLE cycle where STB is first seen as cycle 1.
    stb_cyc = 0;
    expect_rsp(0, 1'b0, 32'h0200_0100);
    req(0, 1'b0, 32'h0200_0100, 32'h0, 1);
    t0 = cyc;
    run("single", 20);
    check("single_lat", last_rsp_cyc - t0 + 1, 3);
    check("single_stb_cycles", stb_cyc, 1);

    // Fresh pointer: continuous requests from both alternate starting with M0.
    do_reset(2);
    for (int i = 0; i < 3; i++) begin
      expect_rsp(0, 1'b0, 32'h0200_0104);
      expect_rsp(1, 1'b0, 32'h0200_0108);
    end
    req(0, 1'b0, 32'h0200_0104, 32'h0, 3);
    req(1, 1'b0, 32'h0200_0108, 32'h0, 3);
    run("alt", 60);
    check("alt_m0_hold", oM0_DAT, 32'h89AB_CDEF);

    // Unmapped address: error pulse after the full timeout.
    expect_rsp(1, 1'b0, 32'h0300_0000);
    req(1, 1'b0, 32'h0300_0000, 32'h0, 1);
    t0 = cyc;
    run("tmo", 60);
    check("tmo_lat", last_rsp_cyc - t0 + 1, TMO + 2);
    check("tmo_idle_gnt", oGNT, 0);
    check("tmo_m0_hold", oM0_DAT, 32'h89AB_CDEF);

    // Write: slave sees WE and data, master gets zero data.
    expect_rsp(0, 1'b1, 32'h0200_0104);
    req(0, 1'b1, 32'h0200_0104, 32'hDEAD_BEEF, 1);
    run("wr", 20);
    check("wr_we", s_we_seen, 1);
    check("wr_adr", s_adr_seen, 32'h0200_0104);
    check("wr_dat", s_dat_seen, 32'hDEAD_BEEF);

    // Reset mid-transfer, then simultaneous requests restart at M0.
    req(1, 1'b0, 32'h0200_0108, 32'h0, 1);
    step();
    check("rstx_gnt", oGNT, 2'b10);
    rst = 1'b1;
    step();
    check_zero("rstx");
    m_stb = 2'b00;
    rem   = '{0, 0};
    step();
    rst = 1'b0;
    expect_rsp(0, 1'b0, 32'h0200_0100);
    expect_rsp(1, 1'b0, 32'h0200_0104);
    req(0, 1'b0, 32'h0200_0100, 32'h0, 1);
    req(1, 1'b0, 32'h0200_0104, 32'h0, 1);
    run("rstx_after", 30);

    // M0 (granted, hung) abandons its request; pending M1 is served next.
    expect_rsp(1, 1'b0, 32'h0200_0100);
    req(0, 1'b0, 32'h0300_0000, 32'h0, 1);
    req(1, 1'b0, 32'h0200_0104, 32'h0, 1);
    m_adr[1] = 32'h0200_0100;
    step();
    check("abort_gnt_m0", oGNT, 2'b01);
    step();
    step();
    m_stb[0] = 1'b0;
    rem[0]   = 0;
    run("abort", 30);
    check("abort_m0_hold", oM0_DAT, 32'h0123_4567);

    // ACK arriving exactly on the timeout cycle beats the timeout.
    s_wait = TMO - 1;
    expect_rsp(0, 1'b0, 32'h0200_0108);
    req(0, 1'b0, 32'h0200_0108, 32'h0, 1);
    t0 = cyc;
    run("edge", 60);
    check("edge_lat", last_rsp_cyc - t0 + 1, TMO + 2);
    s_wait = 0;

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
